// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared state type, defaults and id-width helper for the UART tx arbiter
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2
  } state_e;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_START_TIMEOUT = 65535;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick: first request at or after the pointer
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  always_comb begin
    int j;
    logic [ID_W-1:0] cand;
    j       = 0;
    cand    = '0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    // Explicit wrap keeps the search correct for non-power-of-two NUM_REQ.
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = ID_W'(j);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one Uart8 transmit path between NUM_REQ producers
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int ID_W          = id_width(NUM_REQ),
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [NUM_REQ-1:0]   reqValid,
  input  logic [8*NUM_REQ-1:0] reqData,
  output logic [NUM_REQ-1:0]   reqReady,
  output logic                 txEn,
  output logic                 txStart,
  output logic [7:0]           txData,
  input  logic                 txBusy,
  output logic                 doneValid,
  output logic [ID_W-1:0]      doneId,
  output logic                 timeoutErr,
  output logic                 busy
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic                txen_q, txen_d;
  logic                start_q, start_d;
  logic [7:0]          data_q, data_d;
  logic                done_q, done_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                toerr_q, toerr_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i   (reqValid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ready_q <= '0;
      txen_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      id_q    <= '0;
      toerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      txen_q  <= txen_d;
      start_q <= start_d;
      data_q  <= data_d;
      done_q  <= done_d;
      id_q    <= id_d;
      toerr_q <= toerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ready_d = '0;
    txen_d  = 1'b1;
    start_d = 1'b0;
    data_d  = data_q;
    done_d  = 1'b0;
    id_d    = id_q;
    toerr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A busy line here is a frame left over from before a reset; let it drain first.
        if (pick_any && !txBusy) begin
          data_d  = reqData[{pick_idx, 3'b000} +: 8];
          ready_d = pick_grant;
          start_d = 1'b1;
          id_d    = pick_idx;
          ptr_d   = (pick_idx == ID_LAST) ? '0 : pick_idx + 1'b1;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        start_d = 1'b1;
        // txBusy is checked first so it wins over a timeout on the same edge.
        if (txBusy) begin
          start_d = 1'b0;
          state_d = SEND;
        end else if (cnt_q >= CNT_LAST) begin
          start_d = 1'b0;
          toerr_d = 1'b1;
          state_d = IDLE;
        end
      end
      SEND: begin
        if (!txBusy) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign reqReady   = ready_q;
  assign txEn       = txen_q;
  assign txStart    = start_q;
  assign txData     = data_q;
  assign doneValid  = done_q;
  assign doneId     = id_q;
  assign timeoutErr = toerr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a round-robin reference model
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 20;

  logic          clk;
  logic          rstN;
  logic [N-1:0]  reqValid;
  logic [8*N-1:0] reqData;
  logic [N-1:0]  reqReady;
  logic          txEn;
  logic          txStart;
  logic [7:0]    txData;
  logic          txBusy;
  logic          doneValid;
  logic [1:0]    doneId;
  logic          timeoutErr;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int ptr    = 0;

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .ID_W          (2),
    .START_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .reqValid   (reqValid),
    .reqData    (reqData),
    .reqReady   (reqReady),
    .txEn       (txEn),
    .txStart    (txStart),
    .txData     (txData),
    .txBusy     (txBusy),
    .doneValid  (doneValid),
    .doneId     (doneId),
    .timeoutErr (timeoutErr),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first pending requester scanning upward from the pointer, modulo N.
  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic chk_reset(input string pfx);
    chk({pfx, "_ready"}, reqReady, 0);
    chk({pfx, "_txen"}, txEn, 0);
    chk({pfx, "_txstart"}, txStart, 0);
    chk({pfx, "_txdata"}, txData, 0);
    chk({pfx, "_done"}, doneValid, 0);
    chk({pfx, "_doneid"}, doneId, 0);
    chk({pfx, "_toerr"}, timeoutErr, 0);
    chk({pfx, "_busy"}, busy, 0);
  endtask

  // One frame: grant on the first edge, txBusy rises after d cycles of txStart, stays len cycles.
  task automatic do_frame(input logic [3:0] v, input logic [31:0] data, input int exp_w,
                          input int d, input int len);
    logic [31:0] one_hot;
    one_hot  = 32'd1 << exp_w;
    reqValid = v;
    reqData  = data;
    tick();
    chk("grant_ready", reqReady, one_hot);
    chk("grant_start", txStart, 1);
    chk("grant_data", txData, data[8*exp_w +: 8]);
    chk("grant_id", doneId, exp_w);
    chk("grant_busy", busy, 1);
    chk("grant_no_done", doneValid, 0);
    chk("grant_no_toerr", timeoutErr, 0);
    ptr = (exp_w + 1) % N;
    for (int k = 1; k < d; k++) begin
      tick();
      chk("start_hold", txStart, 1);
      chk("start_ready_pulse", reqReady, 0);
      chk("start_no_toerr", timeoutErr, 0);
    end
    txBusy = 1'b1;
    tick();
    chk("busy_rise_start_low", txStart, 0);
    chk("send_busy", busy, 1);
    chk("send_no_toerr", timeoutErr, 0);
    for (int k = 1; k < len; k++) begin
      tick();
      chk("send_no_done", doneValid, 0);
      chk("send_data_stable", txData, data[8*exp_w +: 8]);
    end
    txBusy = 1'b0;
    tick();
    chk("done_valid", doneValid, 1);
    chk("done_id", doneId, exp_w);
    chk("done_idle", busy, 0);
  endtask

  task automatic do_timeout(input logic [3:0] v, input logic [31:0] data, input int exp_w);
    reqValid = v;
    reqData  = data;
    tick();
    chk("to_grant_ready", reqReady, 32'd1 << exp_w);
    chk("to_grant_start", txStart, 1);
    ptr = (exp_w + 1) % N;
    for (int k = 1; k < TO; k++) begin
      tick();
      chk("to_start_hold", txStart, 1);
      chk("to_err_early", timeoutErr, 0);
    end
    tick();
    chk("to_start_drop", txStart, 0);
    chk("to_err_pulse", timeoutErr, 1);
    chk("to_no_done", doneValid, 0);
    chk("to_idle", busy, 0);
  endtask

  initial begin
    logic [3:0] rv;
    int rw;
    rstN     = 1'b0;
    reqValid = '0;
    reqData  = '0;
    txBusy   = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    rstN = 1'b1;
    tick();
    chk("txen_after_reset", txEn, 1);
    chk("idle_after_reset", busy, 0);

    do_frame(4'b0001, 32'h0000_00A5, 0, 10, 100);

    do_frame(4'b0100, $urandom, 2, 3, 4);
    do_frame(4'b0011, $urandom, 0, 2, 3);
    do_frame(4'b0011, $urandom, 1, 4, 2);
    do_frame(4'b1000, $urandom, 3, 1, 1);

    do_frame(4'b1111, $urandom, 0, 2, 3);
    do_frame(4'b1111, $urandom, 1, 5, 2);
    do_frame(4'b1111, $urandom, 2, 1, 4);
    do_frame(4'b1111, $urandom, 3, 3, 1);
    do_frame(4'b1111, $urandom, 0, 2, 2);
    do_frame(4'b1111, $urandom, 1, 6, 3);

    do_timeout(4'b0100, $urandom, 2);
    do_frame(4'b0001, $urandom, 0, 2, 2);

    do_frame(4'b0010, $urandom, 1, TO, 3);

    for (int n = 0; n < 20; n++) begin
      rv = 4'($urandom_range(1, 15));
      rw = pick(rv, ptr);
      do_frame(rv, $urandom, rw, $urandom_range(1, 12), $urandom_range(1, 8));
    end

    reqValid = 4'b1000;
    reqData  = $urandom;
    rw = pick(4'b1000, ptr);
    tick();
    chk("mid_grant", reqReady, 32'd8);
    reqValid = 4'b0000;
    txBusy   = 1'b1;
    tick();
    chk("mid_send", busy, 1);
    rstN = 1'b0;
    tick();
    chk_reset("mid_reset");
    ptr      = 0;
    rstN     = 1'b1;
    reqValid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stale_no_grant", reqReady, 0);
      chk("stale_idle", busy, 0);
      chk("stale_txen", txEn, 1);
    end
    txBusy = 1'b0;
    do_frame(4'b0100, $urandom, 2, 3, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
